// File: rtl/ifetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
//   XLEN          - address / instruction width
//   NOP_INSTR     - addi x0,x0,0; decode inserts it as a bubble
//   fetch_entry_t - one fetch-queue slot {pc, instr, filled}
package ifetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// fetch_queue: DEPTH-entry in-order buffer of outstanding fetches.
// An entry is allocated (pc known, instr pending) when a request is
// accepted, filled in order as responses return, and popped from the head
// by the IF/ID register.
//   clk, rst      - clock, asynchronous active-high reset
//   clear         - drop all entries (redirect); overrides alloc/fill/pop
//   alloc/alloc_pc- push a new unfilled entry at the tail
//   fill/fill_data- complete the oldest unfilled entry
//   pop           - retire the head entry
//   head          - current head entry (meaningful when alloc_cnt != 0)
//   alloc_cnt     - entries allocated
//   unfilled_cnt  - allocated entries still waiting for their response
module fetch_queue
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               alloc,
    input  logic [XLEN-1:0]    alloc_pc,
    input  logic               fill,
    input  logic [XLEN-1:0]    fill_data,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CW-1:0]      alloc_cnt,
    output logic [CW-1:0]      unfilled_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] hptr;
    logic [PW-1:0] tptr;
    logic [PW-1:0] fptr;

    assign head = mem[hptr];

    // Storage carries no reset: pointers and counts define what is live.
    // Fill is written before alloc so that, at full with a same-cycle pop,
    // a new entry landing in the slot just vacated starts out unfilled.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (fill) begin
                mem[fptr].instr  <= fill_data;
                mem[fptr].filled <= 1'b1;
            end
            if (alloc) begin
                mem[tptr] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hptr         <= '0;
            tptr         <= '0;
            fptr         <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
        end else if (clear) begin
            hptr         <= '0;
            tptr         <= '0;
            fptr         <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
        end else begin
            if (alloc) tptr <= tptr + PW'(1);
            if (fill)  fptr <= fptr + PW'(1);
            if (pop)   hptr <= hptr + PW'(1);
            alloc_cnt    <= alloc_cnt + CW'(alloc) - CW'(pop);
            unfilled_cnt <= unfilled_cnt + CW'(alloc) - CW'(fill);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage between the PC unit and decode.
// Issues in-order imem requests at pc_in, buffers responses in a fetch
// queue, and drives the IF/ID register. Redirects discard queued work and
// count still-outstanding responses so they are thrown away on return.
//   clk, rst         - clock, asynchronous active-high reset
//   pc_in            - current PC from the PC unit
//   pc_advance       - request handshake this cycle; PC unit may step
//   imem_req_*       - request channel (valid/ready, addr = pc_in)
//   imem_resp_*      - in-order response channel, always accepted
//   flush            - redirect: kill IF/ID, queue and in-flight responses
//   id_stall         - decode cannot accept; hold IF/ID
//   if_id_valid/pc/instr - IF/ID pipeline register
module ifetch_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_advance,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            flush,
    input  logic            id_stall,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr
);

    import ifetch_unit_pkg::fetch_entry_t;

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fetch_entry_t  head;
    logic [CW-1:0] alloc_cnt;
    logic [CW-1:0] unfilled_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   in_flight;
    logic [CW:0]   pend_drop;
    logic          req_fire;
    logic          resp_drop;
    logic          resp_fill;
    logic          resp_err;
    logic          resp_taken;
    logic          head_live;
    logic          head_ready;
    logic          bypass;
    logic          pop;

    // Requests in flight are capped by queue slots plus pending drops, so
    // every returning response always has somewhere to go.
    assign in_flight      = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
    assign imem_req_valid = !rst && !flush && (in_flight < DEPTH_W);
    assign imem_req_addr  = pc_in;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_advance     = req_fire;

    // Responses owed to pre-redirect requests are consumed first.
    assign resp_drop = imem_resp_valid && (drop_cnt != '0);
    assign resp_fill = imem_resp_valid && (drop_cnt == '0) && (unfilled_cnt != '0);
    assign resp_err  = imem_resp_valid && (drop_cnt == '0) && (unfilled_cnt == '0);

    // An unfilled head is by definition the oldest unfilled entry, so a
    // response arriving now belongs to it and can go straight to IF/ID.
    assign head_live  = (alloc_cnt != '0);
    assign head_ready = head_live && head.filled;
    assign bypass     = head_live && !head.filled && resp_fill;
    assign pop        = !flush && !id_stall && (head_ready || bypass);

    // On redirect every outstanding response becomes a drop, less the one
    // (if any) arriving this very cycle.
    assign pend_drop  = {1'b0, unfilled_cnt} + {1'b0, drop_cnt};
    assign resp_taken = imem_resp_valid && (pend_drop != '0);

    fetch_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .clear        (flush),
        .alloc        (req_fire),
        .alloc_pc     (pc_in),
        .fill         (resp_fill),
        .fill_data    (imem_resp_data),
        .pop          (pop),
        .head         (head),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (flush) begin
            drop_cnt <= CW'(pend_drop - (CW+1)'(resp_taken));
        end else begin
            drop_cnt <= drop_cnt - CW'(resp_drop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
        end else if (flush) begin
            if_id_valid <= 1'b0;
        end else if (!id_stall) begin
            if (head_ready) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= head.pc;
                if_id_instr <= head.instr;
            end else if (bypass) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= head.pc;
                if_id_instr <= imem_resp_data;
            end else begin
                if_id_valid <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding is an imem protocol violation.
    always_ff @(posedge clk) begin
        if (!rst) assert (!resp_err);
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_in;
    logic            pc_advance;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            flush;
    logic            id_stall;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_instr;

    always #5 clk = ~clk;

    ifetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .pc_advance      (pc_advance),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .flush           (flush),
        .id_stall        (id_stall),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    exp_t exp_q[$];
    req_t pend_q[$];

    int unsigned cycle;
    int unsigned lat;
    int          errors = 0;
    int          checks = 0;

    logic        p_flush, p_stall, p_valid;
    logic [31:0] p_pc, p_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check pc_advance, record accepted requests, apply the
    // edge, check IF/ID against the scoreboard, then drive the imem response.
    task automatic step(input int adv_exp);
        logic fire;
        exp_t e;
        req_t r;
        #3;
        fire = imem_req_valid && imem_req_ready;
        if (adv_exp >= 0) chk("pc_advance", 32'(pc_advance), adv_exp[31:0]);
        if (fire) begin
            chk("req_addr", imem_req_addr, pc_in);
            pend_q.push_back('{addr: pc_in, due: cycle + lat});
            exp_q.push_back('{pc: pc_in, instr: mem_word(pc_in)});
        end
        if (flush) exp_q.delete();
        p_flush = flush;
        p_stall = id_stall;
        p_valid = if_id_valid;
        p_pc    = if_id_pc;
        p_instr = if_id_instr;
        @(posedge clk);
        #1;
        cycle++;
        if (p_flush) begin
            chk("flush_kill", 32'(if_id_valid), 32'd0);
        end else if (p_stall) begin
            chk("hold_valid", 32'(if_id_valid), 32'(p_valid));
            chk("hold_pc", if_id_pc, p_pc);
            chk("hold_instr", if_id_instr, p_instr);
        end else if (if_id_valid) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("ifid_pc", if_id_pc, e.pc);
                chk("ifid_instr", if_id_instr, e.instr);
            end
        end
        if (fire) pc_in = pc_in + 32'd4;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (pend_q.size() != 0 && pend_q[0].due == cycle) begin
            r = pend_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(r.addr);
        end
    endtask

    task automatic drain(input int n);
        imem_req_ready = 1'b0;
        repeat (n) step(0);
        chk("drained_sb", 32'(exp_q.size()), 32'd0);
        chk("drained_imem", 32'(pend_q.size()), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, "_pc"}, if_id_pc, 32'd0);
        chk({tag, "_instr"}, if_id_instr, 32'd0);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_pc_advance"}, 32'(pc_advance), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(dut.drop_cnt), 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        pc_in           = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        flush           = 1'b0;
        id_stall        = 1'b0;
        lat             = 1;
        cycle           = 0;

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst            = 1'b0;
        imem_req_ready = 1'b1;

        // Streaming, 1-cycle imem
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (i >= 1) chk("stream_valid", 32'(if_id_valid), 32'd1);
            if (i == 1) chk("stream_pc0", if_id_pc, 32'h0);
            if (i == 2) chk("stream_pc4", if_id_pc, 32'h4);
        end
        drain(4);

        // Request backpressure at 0x10
        pc_in = 32'h10;
        repeat (3) begin
            step(0);
            chk("bp_addr", imem_req_addr, 32'h10);
            chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
        end
        imem_req_ready = 1'b1;
        step(1);
        drain(4);

        // Decode stall while streaming
        pc_in          = 32'h0;
        imem_req_ready = 1'b1;
        repeat (4) step(1);
        chk("stall_pc8", if_id_pc, 32'h8);
        id_stall = 1'b1;
        step(1);
        step(0);
        step(0);
        step(0);
        chk("stall_hold8", if_id_pc, 32'h8);
        id_stall = 1'b0;
        step(0);
        chk("release_pc_c", if_id_pc, 32'hC);
        step(1);
        chk("release_pc_10", if_id_pc, 32'h10);
        drain(4);

        // Flush with two requests in flight, 3-cycle imem
        lat            = 3;
        pc_in          = 32'h40;
        imem_req_ready = 1'b1;
        step(1);
        step(1);
        flush = 1'b1;
        step(0);
        chk("flush_drop2", 32'(dut.drop_cnt), 32'd2);
        flush = 1'b0;
        pc_in = 32'h100;
        step(0);
        chk("flush_drop1", 32'(dut.drop_cnt), 32'd1);
        step(1);
        chk("flush_drop0", 32'(dut.drop_cnt), 32'd0);
        repeat (6) step(-1);
        drain(6);

        // Flush coinciding with a response and a decode stall
        pc_in          = 32'h200;
        imem_req_ready = 1'b1;
        step(1);
        step(1);
        step(0);
        chk("fsr_resp_present", 32'(imem_resp_valid), 32'd1);
        flush    = 1'b1;
        id_stall = 1'b1;
        step(0);
        chk("fsr_drop1", 32'(dut.drop_cnt), 32'd1);
        flush    = 1'b0;
        id_stall = 1'b0;
        pc_in    = 32'h300;
        step(1);
        chk("fsr_drop0", 32'(dut.drop_cnt), 32'd0);
        repeat (6) step(-1);
        drain(6);

        // Asynchronous reset mid-stream
        lat            = 1;
        pc_in          = 32'h400;
        imem_req_ready = 1'b1;
        repeat (3) step(1);
        chk("pre_rst_valid", 32'(if_id_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        pend_q.delete();
        exp_q.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        pc_in           = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);
        step(1);
        chk("restart_valid", 32'(if_id_valid), 32'd1);
        chk("restart_pc0", if_id_pc, 32'h0);
        step(1);
        chk("restart_pc4", if_id_pc, 32'h4);
        drain(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
